// File: rtl/csr_trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer_pkg
// Shared definitions for the CSR trap sequencer:
//   - machine-mode CSR addresses touched by trap entry and MRET
//   - mstatus bit positions used by the read-modify-write steps
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package csr_trap_sequencer_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_T_MTVEC   = 4'd1,
        ST_T_MEPC    = 4'd2,
        ST_T_MCAUSE  = 4'd3,
        ST_T_MTVAL   = 4'd4,
        ST_T_MSTATUS = 4'd5,
        ST_R_MEPC    = 4'd6,
        ST_R_MSTATUS = 4'd7,
        ST_REDIRECT  = 4'd8
    } seq_state_e;

endpackage

// File: rtl/csr_trap_sequencer_port_mux.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer_port_mux
// Selects who drives the single CSR-file port: the pipeline when the
// sequencer is idle, the sequencer FSM while a sequence is running.
// Ports:
//   i_sel_seq                 1 = sequencer owns the port
//   i_core_addr/wdata/we      pipeline request (we already gated by grant)
//   i_seq_addr/wdata/we       sequencer request
//   o_addr/o_wdata/o_we       to the csr block
// -----------------------------------------------------------------------------
module csr_trap_sequencer_port_mux
    import csr_trap_sequencer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  i_sel_seq,
    input  logic [CSR_ADDR_W-1:0] i_core_addr,
    input  logic [XLEN-1:0]       i_core_wdata,
    input  logic                  i_core_we,
    input  logic [CSR_ADDR_W-1:0] i_seq_addr,
    input  logic [XLEN-1:0]       i_seq_wdata,
    input  logic                  i_seq_we,
    output logic [CSR_ADDR_W-1:0] o_addr,
    output logic [XLEN-1:0]       o_wdata,
    output logic                  o_we
);

    // Port ownership select
    always_comb begin
        o_addr  = i_core_addr;
        o_wdata = i_core_wdata;
        o_we    = i_core_we;
        if (i_sel_seq) begin
            o_addr  = i_seq_addr;
            o_wdata = i_seq_wdata;
            o_we    = i_seq_we;
        end else begin
            o_addr  = i_core_addr;
            o_wdata = i_core_wdata;
            o_we    = i_core_we;
        end
    end

endmodule

// File: rtl/csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer
// Owns the CSR-file access port. Idle: pipeline Zicsr accesses pass through.
// Trap entry: mtvec read -> mepc/mcause/mtval writes -> mstatus RMW -> redirect.
// MRET: mepc read -> mstatus RMW -> redirect. o_redirect_valid is a one-cycle
// pulse carrying the trap target or mepc on o_redirect_pc.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_trap_req/irq/code/pc/tval  trap request and cause data (sampled in IDLE)
//   i_mret_req                MRET request (sampled in IDLE)
//   i_core_csr_*/o_core_csr_* pipeline CSR access and grant/read data
//   o_csr_addr/wdata/we, i_csr_rdata  csr block port (combinational read)
//   o_busy                    sequence in progress
//   o_redirect_valid/pc       fetch redirect pulse and target
// Configuration macro: CSR_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 01 with an interrupt jumps to base + 4*code).
// -----------------------------------------------------------------------------
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter int         CSR_ADDR_W = 12,
    parameter logic [1:0] MPP_VALUE  = 2'b11
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_trap_req,
    input  logic                  i_trap_irq,
    input  logic [3:0]            i_trap_code,
    input  logic [XLEN-1:0]       i_trap_pc,
    input  logic [XLEN-1:0]       i_trap_tval,
    input  logic                  i_mret_req,
    input  logic                  i_core_csr_valid,
    input  logic [CSR_ADDR_W-1:0] i_core_csr_addr,
    input  logic [XLEN-1:0]       i_core_csr_wdata,
    input  logic                  i_core_csr_we,
    output logic                  o_core_csr_ready,
    output logic [XLEN-1:0]       o_core_csr_rdata,
    output logic [CSR_ADDR_W-1:0] o_csr_addr,
    output logic [XLEN-1:0]       o_csr_wdata,
    output logic                  o_csr_we,
    input  logic [XLEN-1:0]       i_csr_rdata,
    output logic                  o_busy,
    output logic                  o_redirect_valid,
    output logic [XLEN-1:0]       o_redirect_pc
);

    localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(CSR_MSTATUS);
    localparam logic [CSR_ADDR_W-1:0] A_MTVEC   = CSR_ADDR_W'(CSR_MTVEC);
    localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(CSR_MEPC);
    localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(CSR_MCAUSE);
    localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(CSR_MTVAL);
    localparam logic [XLEN-1:0]       ALIGN_MASK = ~(XLEN'(3));

    seq_state_e            r_state;
    seq_state_e            w_next_state;
    logic                  r_busy;
    logic                  r_redirect_valid;
    logic [XLEN-1:0]       r_redirect_pc;
    logic                  r_irq;
    logic [3:0]            r_code;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_tval;

    logic                  w_idle;
    logic                  w_trap_accept;
    logic                  w_core_grant;
    logic [XLEN-1:0]       w_target;
    logic [CSR_ADDR_W-1:0] w_seq_addr;
    logic [XLEN-1:0]       w_seq_wdata;
    logic                  w_seq_we;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_trap_accept = w_idle & i_trap_req;
    // A trap or MRET accepted in the same cycle steals the port from the pipeline.
    assign w_core_grant  = w_idle & i_core_csr_valid & ~i_trap_req & ~i_mret_req;

    assign o_core_csr_ready = w_core_grant;
    assign o_core_csr_rdata = i_csr_rdata;
    assign o_busy           = r_busy;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

    // Trap target from the mtvec value being read this cycle
    always_comb begin
        w_target = i_csr_rdata & ALIGN_MASK;
`ifdef CSR_VECTORED_EN
        if ((i_csr_rdata[1:0] == 2'b01) && r_irq) begin
            w_target = (i_csr_rdata & ALIGN_MASK) + (XLEN'(r_code) << 2);
        end else begin
            w_target = i_csr_rdata & ALIGN_MASK;
        end
`endif
    end

    // FSM state register plus registered busy/redirect flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_redirect_valid <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_busy           <= (w_next_state != ST_IDLE);
            r_redirect_valid <= (w_next_state == ST_REDIRECT);
        end
    end

    // FSM next-state logic: trap wins over MRET; sequences run one CSR op per cycle
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (i_trap_req) begin
                    w_next_state = ST_T_MTVEC;
                end else if (i_mret_req) begin
                    w_next_state = ST_R_MEPC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_T_MTVEC:   w_next_state = ST_T_MEPC;
            ST_T_MEPC:    w_next_state = ST_T_MCAUSE;
            ST_T_MCAUSE:  w_next_state = ST_T_MTVAL;
            ST_T_MTVAL:   w_next_state = ST_T_MSTATUS;
            ST_T_MSTATUS: w_next_state = ST_REDIRECT;
            ST_R_MEPC:    w_next_state = ST_R_MSTATUS;
            ST_R_MSTATUS: w_next_state = ST_REDIRECT;
            ST_REDIRECT:  w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: sequencer side of the CSR port; mstatus RMW uses the same-cycle read
    always_comb begin
        w_seq_addr  = A_MSTATUS;
        w_seq_wdata = i_csr_rdata;
        w_seq_we    = 1'b0;
        case (r_state)
            ST_T_MTVEC: begin
                w_seq_addr = A_MTVEC;
            end
            ST_T_MEPC: begin
                w_seq_addr  = A_MEPC;
                w_seq_wdata = r_pc & ALIGN_MASK;
                w_seq_we    = 1'b1;
            end
            ST_T_MCAUSE: begin
                w_seq_addr  = A_MCAUSE;
                w_seq_wdata = {r_irq, {(XLEN-5){1'b0}}, r_code};
                w_seq_we    = 1'b1;
            end
            ST_T_MTVAL: begin
                w_seq_addr  = A_MTVAL;
                w_seq_wdata = r_tval;
                w_seq_we    = 1'b1;
            end
            ST_T_MSTATUS: begin
                w_seq_addr                                  = A_MSTATUS;
                w_seq_wdata[MSTATUS_MPIE]                   = i_csr_rdata[MSTATUS_MIE];
                w_seq_wdata[MSTATUS_MIE]                    = 1'b0;
                w_seq_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = MPP_VALUE;
                w_seq_we                                    = 1'b1;
            end
            ST_R_MEPC: begin
                w_seq_addr = A_MEPC;
            end
            ST_R_MSTATUS: begin
                w_seq_addr                                  = A_MSTATUS;
                w_seq_wdata[MSTATUS_MIE]                    = i_csr_rdata[MSTATUS_MPIE];
                w_seq_wdata[MSTATUS_MPIE]                   = 1'b1;
                w_seq_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = MPP_VALUE;
                w_seq_we                                    = 1'b1;
            end
            default: begin
                w_seq_we = 1'b0;
            end
        endcase
    end

    // Latch trap cause data on acceptance and the redirect target on its read step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq         <= 1'b0;
            r_code        <= 4'd0;
            r_pc          <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else if (w_trap_accept) begin
            r_irq  <= i_trap_irq;
            r_code <= i_trap_code;
            r_pc   <= i_trap_pc;
            r_tval <= i_trap_tval;
        end else if (r_state == ST_T_MTVEC) begin
            r_redirect_pc <= w_target;
        end else if (r_state == ST_R_MEPC) begin
            r_redirect_pc <= i_csr_rdata;
        end
    end

    csr_trap_sequencer_port_mux #(
        .XLEN       (XLEN),
        .CSR_ADDR_W (CSR_ADDR_W)
    ) u_port_mux (
        .i_sel_seq    (r_busy),
        .i_core_addr  (i_core_csr_addr),
        .i_core_wdata (i_core_csr_wdata),
        .i_core_we    (w_core_grant & i_core_csr_we),
        .i_seq_addr   (w_seq_addr),
        .i_seq_wdata  (w_seq_wdata),
        .i_seq_we     (w_seq_we),
        .o_addr       (o_csr_addr),
        .o_wdata      (o_csr_wdata),
        .o_we         (o_csr_we)
    );

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_sequencer
// Directed and randomized bench for csr_trap_sequencer. A simple CSR file
// array stands in for the csr block; a transaction-level model (ref_csr plus
// arithmetic mstatus/target rules) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_csr_trap_sequencer;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MSCR    = 12'h340;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_req, trap_irq, mret_req;
    logic [3:0]  trap_code;
    logic [31:0] trap_pc, trap_tval;
    logic        core_valid, core_we, core_ready;
    logic [11:0] core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_we, busy, redir_valid;
    logic [31:0] redir_pc;

    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_csr [0:4095];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_trap_req       (trap_req),
        .i_trap_irq       (trap_irq),
        .i_trap_code      (trap_code),
        .i_trap_pc        (trap_pc),
        .i_trap_tval      (trap_tval),
        .i_mret_req       (mret_req),
        .i_core_csr_valid (core_valid),
        .i_core_csr_addr  (core_addr),
        .i_core_csr_wdata (core_wdata),
        .i_core_csr_we    (core_we),
        .o_core_csr_ready (core_ready),
        .o_core_csr_rdata (core_rdata),
        .o_csr_addr       (csr_addr),
        .o_csr_wdata      (csr_wdata),
        .o_csr_we         (csr_we),
        .i_csr_rdata      (csr_rdata),
        .o_busy           (busy),
        .o_redirect_valid (redir_valid),
        .o_redirect_pc    (redir_pc)
    );

    // CSR file stand-in: combinational read, write at the rising edge
    assign csr_rdata = csr_mem[csr_addr];
    always @(posedge clk) begin
        if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | ((ms & 32'h8) << 4) | 32'h1800;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | ((ms & 32'h80) >> 4) | 32'h80 | 32'h1800;
    endfunction

    function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic irq,
                                                input logic [3:0] code);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_EN
        if ((mtvec & 32'h3) == 32'h1 && irq) return base + 32'(code) * 32'd4;
`endif
        return base;
    endfunction

    task automatic core_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        core_valid = 1'b1; core_we = 1'b1; core_addr = addr; core_wdata = data;
        #1;
        check("core_wr_ready", {31'd0, core_ready}, 32'd1);
        @(posedge clk);
        #1;
        core_valid = 1'b0; core_we = 1'b0;
        ref_csr[addr] = data;
    endtask

    task automatic core_read(input logic [11:0] addr, input string tag);
        @(negedge clk);
        core_valid = 1'b1; core_we = 1'b0; core_addr = addr;
        #1;
        check("core_rd_ready", {31'd0, core_ready}, 32'd1);
        check(tag, core_rdata, ref_csr[addr]);
        core_valid = 1'b0;
    endtask

    // One trap (is_trap=1) or MRET sequence; noisy adds a colliding MRET and core write
    task automatic run_seq(input bit is_trap, input logic irq, input logic [3:0] code,
                           input logic [31:0] pc, input logic [31:0] tval, input bit noisy,
                           output logic [31:0] got_pc);
        int          lat, seen_k, pulses, busy_n;
        logic [31:0] exp_pc, scr_before;
        lat = is_trap ? 6 : 3;
        scr_before = ref_csr[A_MSCR];
        if (is_trap) begin
            exp_pc = trap_target(ref_csr[A_MTVEC], irq, code);
            ref_csr[A_MEPC]    = pc & 32'hFFFF_FFFC;
            ref_csr[A_MCAUSE]  = {irq, 27'd0, code};
            ref_csr[A_MTVAL]   = tval;
            ref_csr[A_MSTATUS] = trap_mstatus(ref_csr[A_MSTATUS]);
        end else begin
            exp_pc = ref_csr[A_MEPC];
            ref_csr[A_MSTATUS] = mret_mstatus(ref_csr[A_MSTATUS]);
        end
        @(negedge clk);
        trap_req = is_trap; mret_req = !is_trap || noisy;
        trap_irq = irq; trap_code = code; trap_pc = pc; trap_tval = tval;
        if (noisy) begin
            core_valid = 1'b1; core_we = 1'b1; core_addr = A_MSCR; core_wdata = ~scr_before;
            #1;
            check("collide_ready", {31'd0, core_ready}, 32'd0);
            check("collide_we", {31'd0, csr_we}, 32'd0);
        end
        @(posedge clk);
        #1;
        trap_req = 1'b0;
        if (!noisy) mret_req = 1'b0;
        seen_k = 0; pulses = 0; busy_n = 0; got_pc = 32'd0;
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (noisy) check("busy_ready", {31'd0, core_ready}, 32'd0);
            end
            if (redir_valid) begin
                pulses++;
                if (seen_k == 0) begin
                    seen_k = k;
                    got_pc = redir_pc;
                end
                mret_req = 1'b0; core_valid = 1'b0; core_we = 1'b0;
            end
        end
        mret_req = 1'b0; core_valid = 1'b0; core_we = 1'b0;
        check("redirect_latency", 32'(seen_k), 32'(lat));
        check("redirect_pulses", 32'(pulses), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'(lat));
        check("redirect_pc", got_pc, exp_pc);
        check("mem_mepc", csr_mem[A_MEPC], ref_csr[A_MEPC]);
        check("mem_mcause", csr_mem[A_MCAUSE], ref_csr[A_MCAUSE]);
        check("mem_mtval", csr_mem[A_MTVAL], ref_csr[A_MTVAL]);
        check("mem_mstatus", csr_mem[A_MSTATUS], ref_csr[A_MSTATUS]);
        if (noisy) check("collide_no_write", csr_mem[A_MSCR], scr_before);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] mtv, ms;
        rst_n = 1'b0;
        trap_req = 1'b0; trap_irq = 1'b0; trap_code = 4'd0; trap_pc = 32'd0; trap_tval = 32'd0;
        mret_req = 1'b0; core_valid = 1'b0; core_we = 1'b0; core_addr = 12'd0; core_wdata = 32'd0;

        // Reset state
        #8;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_redirect", {31'd0, redir_valid}, 32'd0);
        check("rst_csr_we", {31'd0, csr_we}, 32'd0);
        check("rst_ready", {31'd0, core_ready}, 32'd0);
        check("rst_redirect_pc", redir_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pipeline pass-through
        core_write(A_MSTATUS, 32'h0000_0088);
        core_read(A_MSTATUS, "core_readback");
        check("core_readback_const", core_rdata, 32'h0000_0088);

        // Directed trap
        core_write(A_MTVEC, 32'h0000_0100);
        core_write(A_MSTATUS, 32'h0000_0008);
        core_write(A_MSCR, 32'h0000_5555);
        run_seq(1'b1, 1'b0, 4'd2, 32'h0000_2004, 32'h0000_DEAD, 1'b0, got);
        check("dir_trap_pc", got, 32'h0000_0100);
        check("dir_mepc", csr_mem[A_MEPC], 32'h0000_2004);
        check("dir_mcause", csr_mem[A_MCAUSE], 32'h0000_0002);
        check("dir_mtval", csr_mem[A_MTVAL], 32'h0000_DEAD);
        check("dir_trap_mstatus", csr_mem[A_MSTATUS], 32'h0000_1880);

        // MRET after trap
        run_seq(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, got);
        check("dir_mret_pc", got, 32'h0000_2004);
        check("dir_mret_mstatus", csr_mem[A_MSTATUS], 32'h0000_1888);

        // Trap + MRET + core write in one cycle, with requests held during busy
        run_seq(1'b1, 1'b0, 4'd5, 32'h0000_3002, 32'h0000_1234, 1'b1, got);
        core_read(A_MSCR, "scratch_kept");

        // Vectored interrupt target
        core_write(A_MTVEC, 32'h0000_0101);
        run_seq(1'b1, 1'b1, 4'd7, 32'h0000_4000, 32'd0, 1'b0, got);
`ifdef CSR_VECTORED_EN
        check("vec_target", got, 32'h0000_011C);
`else
        check("vec_target", got, 32'h0000_0100);
`endif
        check("vec_mcause", csr_mem[A_MCAUSE], 32'h8000_0007);

        // Randomized traps and MRETs
        for (int i = 0; i < 12; i++) begin
            mtv = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            ms  = $urandom();
            core_write(A_MTVEC, mtv);
            core_write(A_MSTATUS, ms);
            run_seq(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                    $urandom(), 1'($urandom_range(0, 1)), got);
            if ($urandom_range(0, 1) == 1) run_seq(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, got);
        end

        // Reset mid-trap: mepc already written, later steps never happen
        core_write(A_MTVEC, 32'h0000_0200);
        @(negedge clk);
        trap_req = 1'b1; trap_irq = 1'b0; trap_code = 4'd3; trap_pc = 32'h0000_5006;
        trap_tval = 32'h0000_0077;
        @(posedge clk);
        #1;
        trap_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_redirect", {31'd0, redir_valid}, 32'd0);
        check("midrst_csr_we", {31'd0, csr_we}, 32'd0);
        check("midrst_redirect_pc", redir_pc, 32'd0);
        ref_csr[A_MEPC] = 32'h0000_5004;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, busy, redir_valid}, 32'd0);
        end
        check("midrst_mepc", csr_mem[A_MEPC], ref_csr[A_MEPC]);
        check("midrst_mcause", csr_mem[A_MCAUSE], ref_csr[A_MCAUSE]);
        check("midrst_mtval", csr_mem[A_MTVAL], ref_csr[A_MTVAL]);
        check("midrst_mstatus", csr_mem[A_MSTATUS], ref_csr[A_MSTATUS]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
